traffic_timer_ctrl: RTL and testbench
=====================================

// Module: traffic_timer_ctrl
// PURPOSE
//   Timing sequencer for traffic_fsm. Divides clk into 1-second ticks and runs the
//   per-light countdown. Drives the FSM handshake inputs second_cnt_pre_last and
//   light_cnt_last. Holds runtime-programmable green/yellow/red durations.
//   Sits between the system clock domain and traffic_fsm; remain_sec feeds the display.
// PARAMETERS
//   CLK_PER_SEC        50  clk cycles per second (>=2; 50_000_000 on board)
//   CNT_W              8   width of duration registers and remain_sec
//   LIGHT_STATE_WIDTH  3   one-hot light encoding {red,yellow,green}
//   GREEN_SEC          10  reset value of green duration, in seconds (1..2^CNT_W-1)
//   YELLOW_SEC         3   reset value of yellow duration
//   RED_SEC            12  reset value of red duration
// PORTS
//   clk                  in   1       system clock, rising edge
//   rst                  in   1       asynchronous, active-high reset
//   en                   in   1       count enable; shared with traffic_fsm
//   light                in   3       current light from FSM: 001 green, 010 yellow, 100 red
//   cfg_wr               in   1       duration write strobe
//   cfg_sel              in   2       0 green, 1 yellow, 2 red, 3 ignored
//   cfg_data             in   CNT_W   new duration in seconds
//   second_cnt_pre_last  out  1       high 1 cycle, one cycle before each second tick
//   sec_tick             out  1       high 1 cycle at the last cycle of each second
//   light_cnt_last       out  1       level: high while remain_sec==1
//   remain_sec           out  CNT_W   seconds left in current light (D..1)
// BEHAVIOUR
//   One clock (clk). Reset is asynchronous and active-high (rst); all flops clear on rst.
//   Reset values:
//     - sec_cnt=0; remain_sec=GREEN_SEC; light_q=001.
//     - dur_g/y/r = GREEN_SEC/YELLOW_SEC/RED_SEC.
//     - All pulse outputs 0.
//   Prescaler sec_cnt:
//     - When en: counts 0..CLK_PER_SEC-1, then wraps to 0. When en=0: holds.
//     - second_cnt_pre_last = en & (sec_cnt==CLK_PER_SEC-2). Combinational from registers.
//     - sec_tick = en & (sec_cnt==CLK_PER_SEC-1).
//   Countdown:
//     - When sec_tick and remain_sec>1: decrement remain_sec.
//     - light_cnt_last = (remain_sec==1). Not gated by en.
//   Reload:
//     - Trigger A: light != light_q (light_q = light registered every cycle, regardless of en).
//     - Trigger B: sec_tick & remain_sec==1.
//     - On either trigger: remain_sec <= dur[light] and sec_cnt <= 0.
//     - Both triggers in the same cycle give the same single reload. This is the normal
//       closed-loop case: the FSM updates light on the edge after pre_last&last, so the new
//       light appears during the sec_tick cycle.
//     - Trigger A also fires when en=0. Example: FSM reset to green mid-count forces a
//       reload to green.
//     - light not one-hot (000, 011, 111, ...): reload uses dur_r (fail-safe red).
//   Config:
//     - cfg_wr writes dur[cfg_sel] at the clock edge. cfg_sel=3: no effect.
//     - cfg_data==0 is stored as 1.
//     - A write never alters a running remain_sec; it applies from the next reload.
//     - Write and reload of the same register in the same cycle: reload uses the OLD
//       value; the new value is stored for the following reload.
//   Latency:
//     - light change -> remain_sec reloaded on the next edge (1 cycle).
//     - Second boundary -> FSM light change: second_cnt_pre_last leads sec_tick by exactly 1 cycle.
//   Reset mid-operation: immediate return to reset values; no pulse emitted during rst.
// TESTING  (CLK_PER_SEC=4, GREEN_SEC=3, YELLOW_SEC=2, RED_SEC=4, CNT_W=8)
//   1. rst then en=1, light=001 -> pre_last at sec_cnt=2 and sec_tick at sec_cnt=3, every
//      4 cycles; remain 3,2,1; light_cnt_last high during the 3rd second.
//   2. Closed loop with traffic_fsm -> light goes 001->010->100->001; remain loads 2, 4, 3
//      at the sec_tick of each change; full cycle = 36 clk.
//   3. cfg_wr sel=0 data=5 during yellow -> current count unaffected; next green loads 5.
//      Then sel=1 data=0 -> next yellow loads 1.
//   4. en=0 at sec_cnt=1, remain=2, held 7 cycles -> sec_cnt/remain frozen, no pulses.
//      On en=1, count resumes from sec_cnt=1.
//   5. light forced 010->001 mid-count (sec_cnt=2) -> next edge remain=3, sec_cnt=0,
//      no pre_last pulse in that cycle. Also light=011 -> remain=4 (red).
//   6. rst asserted mid-second, asynchronously -> outputs go to reset values before the
//      next clk edge; same-cycle write+reload of dur_g -> old value loaded, new value next time.

Source files
------------

// File: rtl/traffic_timer_ctrl.sv
// rtl/traffic_timer_ctrl.sv - one-second prescaler and per-light countdown for traffic_fsm
//
// Purpose:
//   Divides clk_i into one-second ticks, counts down the seconds left in the
//   current light and gives traffic_fsm its two handshake inputs. Holds the
//   green/yellow/red durations, which can be rewritten at run time.
//
// Ports:
//   clk_i                  system clock, rising edge
//   rst_i                  asynchronous active-high reset
//   en_i                   count enable, shared with traffic_fsm
//   light_i                current light from the FSM: 001 green, 010 yellow, 100 red
//   cfg_wr_i               duration write strobe
//   cfg_sel_i              0 green, 1 yellow, 2 red, 3 ignored
//   cfg_data_i             new duration in seconds (0 is stored as 1)
//   second_cnt_pre_last_o  one-cycle pulse, one cycle before each second tick
//   sec_tick_o             one-cycle pulse on the last cycle of each second
//   light_cnt_last_o       level, high while remain_sec_o == 1
//   remain_sec_o           seconds left in the current light (D..1)

module traffic_timer_ctrl #(
  parameter int CLK_PER_SEC       = 50,
  parameter int CNT_W             = 8,
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int GREEN_SEC         = 10,
  parameter int YELLOW_SEC        = 3,
  parameter int RED_SEC           = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_i,
  input  logic                         cfg_wr_i,
  input  logic [1:0]                   cfg_sel_i,
  input  logic [CNT_W-1:0]             cfg_data_i,
  output logic                         second_cnt_pre_last_o,
  output logic                         sec_tick_o,
  output logic                         light_cnt_last_o,
  output logic [CNT_W-1:0]             remain_sec_o
);

  localparam int SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [SEC_W-1:0] SEC_PRE_LAST = SEC_W'(CLK_PER_SEC - 2);
  localparam logic [SEC_W-1:0] SEC_LAST     = SEC_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_ONE      = SEC_W'(1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [LIGHT_STATE_WIDTH-1:0] LIGHT_GREEN  = LIGHT_STATE_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] LIGHT_YELLOW = LIGHT_STATE_WIDTH'(2);
  localparam logic [LIGHT_STATE_WIDTH-1:0] LIGHT_RED    = LIGHT_STATE_WIDTH'(4);

  localparam logic [1:0] SEL_GREEN  = 2'd0;
  localparam logic [1:0] SEL_YELLOW = 2'd1;
  localparam logic [1:0] SEL_RED    = 2'd2;

  // State
  logic [SEC_W-1:0]             sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]             remain_q,  remain_d;
  logic [LIGHT_STATE_WIDTH-1:0] light_q;
  logic [CNT_W-1:0]             dur_g_q,   dur_g_d;
  logic [CNT_W-1:0]             dur_y_q,   dur_y_d;
  logic [CNT_W-1:0]             dur_r_q,   dur_r_d;

  // Decoded control
  logic             pre_last;
  logic             tick;
  logic             light_changed;
  logic             reload;
  logic [CNT_W-1:0] reload_dur;
  logic [CNT_W-1:0] cfg_val;

  always_comb begin
    // Pulses are masked during reset so nothing leaks out while rst_i is high,
    // even for CLK_PER_SEC == 2 where the pre-last count equals the reset count.
    pre_last      = ~rst_i & en_i & (sec_cnt_q == SEC_PRE_LAST);
    tick          = ~rst_i & en_i & (sec_cnt_q == SEC_LAST);
    light_changed = (light_i != light_q);

    // A light change and the end of the last second normally coincide in
    // closed loop; both simply request the same reload.
    reload = light_changed | (tick & (remain_q == CNT_ONE));

    // Durations are read from the current registers, so a write landing on
    // the reload edge only takes effect at the following reload.
    // Anything that is not a clean one-hot light falls back to red.
    reload_dur = dur_r_q;
    case (light_i)
      LIGHT_GREEN:  reload_dur = dur_g_q;
      LIGHT_YELLOW: reload_dur = dur_y_q;
      LIGHT_RED:    reload_dur = dur_r_q;
      default:      reload_dur = dur_r_q;
    endcase

    // A zero duration would stall the countdown, so it is clamped to one second.
    cfg_val = (cfg_data_i == '0) ? CNT_ONE : cfg_data_i;

    // Prescaler
    sec_cnt_d = sec_cnt_q;
    if (reload) begin
      sec_cnt_d = '0;
    end else if (en_i) begin
      sec_cnt_d = (sec_cnt_q == SEC_LAST) ? '0 : sec_cnt_q + SEC_ONE;
    end

    // Countdown
    remain_d = remain_q;
    if (reload) begin
      remain_d = reload_dur;
    end else if (tick && (remain_q > CNT_ONE)) begin
      remain_d = remain_q - CNT_ONE;
    end

    // Duration registers
    dur_g_d = dur_g_q;
    dur_y_d = dur_y_q;
    dur_r_d = dur_r_q;
    if (cfg_wr_i) begin
      case (cfg_sel_i)
        SEL_GREEN:  dur_g_d = cfg_val;
        SEL_YELLOW: dur_y_d = cfg_val;
        SEL_RED:    dur_r_d = cfg_val;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sec_cnt_q <= '0;
      remain_q  <= CNT_W'(GREEN_SEC);
      light_q   <= LIGHT_GREEN;
      dur_g_q   <= CNT_W'(GREEN_SEC);
      dur_y_q   <= CNT_W'(YELLOW_SEC);
      dur_r_q   <= CNT_W'(RED_SEC);
    end else begin
      sec_cnt_q <= sec_cnt_d;
      remain_q  <= remain_d;
      // Tracked every cycle, independent of en_i, so an FSM reset while the
      // count is paused still forces a reload.
      light_q   <= light_i;
      dur_g_q   <= dur_g_d;
      dur_y_q   <= dur_y_d;
      dur_r_q   <= dur_r_d;
    end
  end

  assign second_cnt_pre_last_o = pre_last;
  assign sec_tick_o            = tick;
  assign light_cnt_last_o      = (remain_q == CNT_ONE);
  assign remain_sec_o          = remain_q;

endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// tb/tb_traffic_timer_ctrl.sv - self-checking bench for traffic_timer_ctrl

module tb_traffic_timer_ctrl;

  localparam int CPS = 4;
  localparam int GS  = 3;
  localparam int YS  = 2;
  localparam int RS  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] light = 3'b001;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       pre_last, sec_tick, cnt_last;
  logic [7:0] remain;

  int checks = 0;
  int failures = 0;

  // Reference model: seconds-level bookkeeping in plain integers
  int         m_sec;
  int         m_rem;
  int         m_dur[3];
  logic [2:0] m_lightq;

  traffic_timer_ctrl #(
    .CLK_PER_SEC(CPS), .CNT_W(8), .LIGHT_STATE_WIDTH(3),
    .GREEN_SEC(GS), .YELLOW_SEC(YS), .RED_SEC(RS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .light_i(light),
    .cfg_wr_i(cfg_wr), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .second_cnt_pre_last_o(pre_last), .sec_tick_o(sec_tick),
    .light_cnt_last_o(cnt_last), .remain_sec_o(remain)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int light_idx(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] next_light(input logic [2:0] l);
    case (l)
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic void model_reset();
    m_sec    = 0;
    m_rem    = GS;
    m_dur[0] = GS;
    m_dur[1] = YS;
    m_dur[2] = RS;
    m_lightq = 3'b001;
  endfunction

  // One clock edge of the timer, in terms of seconds and durations
  function automatic void model_step(input logic e, input logic [2:0] l, input logic w,
                                     input logic [1:0] s, input int d);
    bit tick_now = e && (m_sec == CPS - 1);
    if ((l != m_lightq) || (tick_now && m_rem == 1)) begin
      m_rem = m_dur[light_idx(l)];
      m_sec = 0;
    end else begin
      if (tick_now && m_rem > 1) m_rem = m_rem - 1;
      if (e) m_sec = (m_sec + 1) % CPS;
    end
    if (w && s != 2'd3) m_dur[s] = (d == 0) ? 1 : d;
    m_lightq = l;
  endfunction

  // Applies inputs for one cycle, samples outputs at the negedge, checks them
  // against the model when chk is set, then advances to posedge+1.
  task automatic do_cycle(input logic e, input logic [2:0] l, input logic w,
                          input logic [1:0] s, input logic [7:0] d, input bit chk,
                          output logic a_pre, output logic a_tick,
                          output logic a_last, output logic [7:0] a_rem);
    en = e; light = l; cfg_wr = w; cfg_sel = s; cfg_data = d;
    @(negedge clk);
    a_pre = pre_last; a_tick = sec_tick; a_last = cnt_last; a_rem = remain;
    if (chk) begin
      check("model_pre_last", int'(a_pre),  int'(e && m_sec == CPS - 2));
      check("model_sec_tick", int'(a_tick), int'(e && m_sec == CPS - 1));
      check("model_cnt_last", int'(a_last), int'(m_rem == 1));
      check("model_remain",   int'(a_rem),  m_rem);
    end
    model_step(e, l, w, s, int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; light = 3'b001; cfg_wr = 1'b0;
    @(negedge clk);
    check("rst_remain",   int'(remain),   GS);
    check("rst_pre_last", int'(pre_last), 0);
    check("rst_sec_tick", int'(sec_tick), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] light;
    logic       pre;
    logic       tick;
    logic       last;
    int         rem;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mkv(input logic p, input logic t, input logic ls, input int r);
    vec_t v;
    v.en = 1'b1; v.light = 3'b001; v.pre = p; v.tick = t; v.last = ls; v.rem = r;
    return v;
  endfunction

  initial begin
    logic       a_pre, a_tick, a_last;
    logic [7:0] a_rem;
    logic [2:0] cl_light;
    bit         pend, armed, chk_now;
    int         starts[$];

    // Open-loop green countdown from reset, one row per clock
    tbl[0]  = mkv(0, 0, 0, 3);  tbl[1]  = mkv(0, 0, 0, 3);
    tbl[2]  = mkv(1, 0, 0, 3);  tbl[3]  = mkv(0, 1, 0, 3);
    tbl[4]  = mkv(0, 0, 0, 2);  tbl[5]  = mkv(0, 0, 0, 2);
    tbl[6]  = mkv(1, 0, 0, 2);  tbl[7]  = mkv(0, 1, 0, 2);
    tbl[8]  = mkv(0, 0, 1, 1);  tbl[9]  = mkv(0, 0, 1, 1);
    tbl[10] = mkv(1, 0, 1, 1);  tbl[11] = mkv(0, 1, 1, 1);
    tbl[12] = mkv(0, 0, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      do_cycle(tbl[i].en, tbl[i].light, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
      check($sformatf("vec%0d_pre", i),    int'(a_pre),  int'(tbl[i].pre));
      check($sformatf("vec%0d_tick", i),   int'(a_tick), int'(tbl[i].tick));
      check($sformatf("vec%0d_last", i),   int'(a_last), int'(tbl[i].last));
      check($sformatf("vec%0d_remain", i), int'(a_rem),  tbl[i].rem);
    end

    // Closed loop with an emulated traffic_fsm: light advances on the edge
    // after pre_last & last, so it shows the new light in the tick cycle.
    do_reset();
    cl_light = 3'b001; pend = 0; chk_now = 0;
    for (int c = 0; c < 80; c++) begin
      armed = 0;
      if (pend) begin
        cl_light = next_light(cl_light);
        pend = 0;
        armed = 1;
        if (cl_light == 3'b001) starts.push_back(c);
      end
      do_cycle(1'b1, cl_light, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
      if (armed) check("loop_tick_at_change", int'(a_tick), 1);
      if (chk_now) check("loop_reload", int'(a_rem), (cl_light == 3'b001) ? GS :
                                                     (cl_light == 3'b010) ? YS : RS);
      chk_now = armed;
      if (a_pre && a_last) pend = 1;
    end
    check("loop_green_entries", starts.size(), 2);
    if (starts.size() == 2) check("loop_period", starts[1] - starts[0], 36);

    // Duration writes during yellow, zero clamp, sel=3 ignored
    do_reset();
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b010, 1'b1, 2'd0, 8'd5, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_yellow_loaded", int'(a_rem), YS);
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_running_untouched", int'(a_rem), YS);
    do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b001, 1'b1, 2'd1, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_new_green", int'(a_rem), 5);
    do_cycle(1'b0, 3'b001, 1'b1, 2'd3, 8'd9, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_zero_as_one", int'(a_rem), 1);
    check("cfg_zero_last", int'(a_last), 1);
    do_cycle(1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_sel3_red", int'(a_rem), RS);
    do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("cfg_sel3_green", int'(a_rem), 5);

    // Enable held low at sec_cnt=1, remain=2
    do_reset();
    repeat (5) do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    for (int i = 0; i < 7; i++) begin
      do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
      check("hold_no_pulse", int'(a_pre | a_tick), 0);
      check("hold_remain", int'(a_rem), 2);
    end
    do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("resume_sec1", int'(a_pre), 0);
    do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("resume_sec2_pre", int'(a_pre), 1);
    do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("resume_sec3_tick", int'(a_tick), 1);

    // Forced light change mid-second, then a non-one-hot light
    do_reset();
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    repeat (2) do_cycle(1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("force_green_remain", int'(a_rem), GS);
    check("force_no_pulse", int'(a_pre | a_tick), 0);
    do_cycle(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("bad_light_red", int'(a_rem), RS);

    // Asynchronous reset between clock edges
    en = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_remain", int'(remain), GS);
    check("async_rst_pulses", int'(pre_last | sec_tick | cnt_last), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write and reload of dur_g on the same edge
    do_cycle(1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b001, 1'b1, 2'd0, 8'd7, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("wr_reload_old", int'(a_rem), GS);
    do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    do_cycle(1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, a_pre, a_tick, a_last, a_rem);
    check("wr_reload_new", int'(a_rem), 7);

    // Randomized run against the model, mixing closed-loop and forced lights
    do_reset();
    cl_light = 3'b001; pend = 0;
    for (int c = 0; c < 1500; c++) begin
      logic       r_en, r_wr;
      logic [1:0] r_sel;
      logic [7:0] r_data;
      if (pend) begin
        cl_light = next_light(cl_light);
        pend = 0;
      end else if ($urandom_range(0, 40) == 0) begin
        cl_light = 3'($urandom);
      end
      r_en   = ($urandom_range(0, 7) != 0);
      r_wr   = ($urandom_range(0, 9) == 0);
      r_sel  = 2'($urandom);
      r_data = 8'($urandom_range(0, 6));
      do_cycle(r_en, cl_light, r_wr, r_sel, r_data, 1'b1, a_pre, a_tick, a_last, a_rem);
      if (a_pre && a_last) pend = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
